ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and destination that the ID/EX pipeline register presents to EX.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in radix-2, one bit per cycle.
- Holds the pipeline through a stall request to ctrl until the result is ready, then hands the result and write-back info to EX for the EX/MEM register.

---
 rtl/ex_muldiv.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
//
// Radix-2, one bit per cycle: a shift-add multiplier and a restoring divider.
// The operands are converted to magnitudes when the op starts, and the sign
// is put back in the FIN cycle. ctrl is asked to stall the pipeline until
// the one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      EX holds a valid M op (sampled only in IDLE)
//   funct3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   reg1/reg2  rs1 / rs2 operands
//   wd_i       destination register address
//   wreg_i     write enable from ID
//   kill       synchronous abort of the op in flight
//   stall_req  stall request to ctrl (combinational)
//   busy       FSM is not idle
//   done       one-cycle pulse, result valid
//   result     final value (held until the next completion)
//   wd_o       latched destination address
//   wreg_o     latched write enable (qualify with done)
//
// Optional build macro MULDIV_FASTPATH_EN: divide-by-zero, signed-overflow
// and zero-operand multiplies skip CALC and go straight to FIN.
module ex_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            kill,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [4:0]        r_wd;
  logic              r_wreg;
  logic              r_neg;      // sign of product / quotient
  logic              r_neg_rem;  // sign of remainder
  logic              r_div0;
  logic              r_ovf;
  logic [XLEN-1:0]   r_rs1;      // raw rs1, returned by REM on divide-by-zero

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mpl;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;

  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_wd_o;
  logic              r_wreg_o;

  // Operand decode at start
  logic            w_sgn1;
  logic            w_sgn2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;

  always_comb begin
    w_sgn1 = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_sgn2 = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_neg1 = w_sgn1 && reg1[XLEN-1];
    w_neg2 = w_sgn2 && reg2[XLEN-1];
    w_mag1 = w_neg1 ? (~reg1 + 1'b1) : reg1;
    w_mag2 = w_neg2 ? (~reg2 + 1'b1) : reg2;
    w_div0 = funct3[2] && (reg2 == '0);
    w_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
             (reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (reg2 == '1);
  end

`ifdef MULDIV_FASTPATH_EN
  logic w_mzero;
  logic r_mzero;
  assign w_mzero = !funct3[2] && ((reg1 == '0) || (reg2 == '0));
  assign w_fast  = w_div0 || w_ovf || w_mzero;
`else
  assign w_fast  = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state; kill overrides everything, including start in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !kill) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (kill) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Restoring divide step: shift in the next dividend bit, subtract if it fits
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;

  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_dvsr});
    w_sub   = w_shift[XLEN-1:0] - r_dvsr;
  end

  // Sign correction and output select for FIN
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_prod  = r_neg ? (~r_acc + 1'b1) : r_acc;
    w_quo_s = r_neg ? (~r_quo + 1'b1) : r_quo;
    w_rem_s = r_neg_rem ? (~r_rem + 1'b1) : r_rem;
    unique case (r_funct3)
      3'd0:                w_final = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_final = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_final = w_quo_s;
      default:             w_final = w_rem_s;
    endcase
    if (r_div0) begin
      w_final = r_funct3[1] ? r_rs1 : '1;
    end else if (r_ovf) begin
      w_final = r_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef MULDIV_FASTPATH_EN
    if (r_mzero) begin
      w_final = '0;
    end
`endif
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_rs1     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mpl     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_wd_o    <= '0;
      r_wreg_o  <= 1'b0;
`ifdef MULDIV_FASTPATH_EN
      r_mzero   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_funct3  <= funct3;
        r_wd      <= wd_i;
        r_wreg    <= wreg_i;
        r_neg     <= w_neg1 ^ w_neg2;
        r_neg_rem <= w_neg1;
        r_div0    <= w_div0;
        r_ovf     <= w_ovf;
        r_rs1     <= reg1;
        r_acc     <= '0;
        r_mcand   <= {{XLEN{1'b0}}, w_mag1};
        r_mpl     <= w_mag2;
        r_quo     <= w_mag1;
        r_rem     <= '0;
        r_dvsr    <= w_mag2;
`ifdef MULDIV_FASTPATH_EN
        r_mzero   <= w_mzero;
`endif
      end else if ((r_state == S_CALC) && !kill) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_funct3[2]) begin
          r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
        end else begin
          if (r_mpl[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mpl   <= r_mpl >> 1;
        end
      end

      r_done <= (r_state == S_FIN) && !kill;
      if ((r_state == S_FIN) && !kill) begin
        r_result <= w_final;
        r_wd_o   <= r_wd;
        r_wreg_o <= r_wreg;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  // The done cycle is always spent in IDLE, so busy already excludes it.
  assign stall_req = start || busy;
  assign done      = r_done && !kill;
  assign wreg_o    = r_wreg_o && !kill;
  assign wd_o      = r_wd_o;
  assign result    = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        kill;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wd_o;
  logic        wreg_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .reg1(reg1), .reg2(reg2), .wd_i(wd_i), .wreg_i(wreg_i), .kill(kill),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result),
    .wd_o(wd_o), .wreg_o(wreg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] ua64;
    logic [63:0] ub64;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'h0, b});
    ua64 = {32'h0, a};
    ub64 = {32'h0, b};
    case (f)
      3'd0: begin p = ua64 * ub64; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (f[2] && b == 0) ||
              ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
              (!f[2] && (a == 0 || b == 0));
`ifdef MULDIV_FASTPATH_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  // Transaction model: which edge accepted the op, how long it takes, what it returns
  int          edge_n   = 0;
  bit          m_active = 1'b0;
  int          m_s      = 0;
  int          m_lat    = 0;
  logic [31:0] m_res    = '0;
  logic [4:0]  m_wd     = '0;
  logic        m_wreg   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
    end else begin
      edge_n = edge_n + 1;
      if (kill) begin
        m_active = 1'b0;
      end else if (start && !(m_active && (edge_n - 1) >= m_s && (edge_n - 1) < m_s + m_lat)) begin
        m_active = 1'b1;
        m_s      = edge_n;
        m_lat    = ref_lat(funct3, reg1, reg2);
        m_res    = ref_op(funct3, reg1, reg2);
        m_wd     = wd_i;
        m_wreg   = wreg_i;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit eb;
    bit ed;
    eb = m_active && edge_n >= m_s && edge_n < m_s + m_lat;
    ed = m_active && edge_n == m_s + m_lat && !kill;
    chk("busy", 32'(busy), 32'(eb));
    chk("stall_req", 32'(stall_req), 32'(start | eb));
    chk("done", 32'(done), 32'(ed));
    if (ed) begin
      chk("result", result, m_res);
      chk("wd_o", 32'(wd_o), 32'(m_wd));
      chk("wreg_o", 32'(wreg_o), 32'(m_wreg));
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic w, input logic [31:0] lit);
    chk("model_pin", ref_op(f, a, b), lit);
    @(negedge clk); #1;
    funct3 = f; reg1 = a; reg2 = b; wd_i = wd; wreg_i = w; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wd, input logic w, input logic [31:0] lit);
    issue(f, a, b, wd, w, lit);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst = 1'b0; start = 1'b0; funct3 = '0; reg1 = '0; reg2 = '0;
    wd_i = '0; wreg_i = 1'b0; kill = 1'b0;
    #3;
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wd_o", 32'(wd_o), 32'h0);
    chk("rst_wreg_o", 32'(wreg_o), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #9 rst = 1'b1;

    run(3'd0, 32'd7,        32'hFFFFFFFA, 5'd1,  1'b1, 32'hFFFFFFD6);
    run(3'd1, 32'h80000000, 32'h80000000, 5'd2,  1'b1, 32'h40000000);
    run(3'd3, 32'h80000000, 32'h80000000, 5'd3,  1'b0, 32'h40000000);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  1'b1, 32'hFFFFFFFF);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  1'b1, 32'hFFFFFFFE);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b1, 32'h00000000);
    run(3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  1'b1, 32'hFFFFFFFD);
    run(3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  1'b1, 32'hFFFFFFFF);
    run(3'd5, 32'd100,      32'd7,        5'd9,  1'b1, 32'd14);
    run(3'd7, 32'd100,      32'd7,        5'd10, 1'b1, 32'd2);
    run(3'd4, 32'd20,       32'hFFFFFFFD, 5'd11, 1'b1, 32'hFFFFFFFA);
    run(3'd6, 32'd20,       32'hFFFFFFFD, 5'd12, 1'b1, 32'd2);
    run(3'd5, 32'd5,        32'd0,        5'd13, 1'b1, 32'hFFFFFFFF);
    run(3'd6, 32'd5,        32'd0,        5'd14, 1'b1, 32'd5);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1'b1, 32'h80000000);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b1, 32'h00000000);
    run(3'd0, 32'd0,        32'd12345,    5'd17, 1'b1, 32'h00000000);

    // Kill a DIV at the 10th edge after it was accepted
    issue(3'd4, 32'd1000, 32'd3, 5'd18, 1'b1, 32'd333);
    repeat (9) @(negedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    chk("kill_busy", 32'(busy), 32'h0);
    chk("kill_stall", 32'(stall_req), 32'h0);
    #1 kill = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("nodone_after_kill", 32'(saw), 32'h0);
    run(3'd0, 32'd123, 32'd456, 5'd19, 1'b1, 32'd56088);

    // Asynchronous reset in the middle of CALC
    issue(3'd5, 32'd999, 32'd10, 5'd20, 1'b1, 32'd99);
    repeat (10) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_wd_o", 32'(wd_o), 32'h0);
    chk("arst_wreg_o", 32'(wreg_o), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_stall", 32'(stall_req), 32'h0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);

    // start pulsed while busy must not re-latch
    issue(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd9, 1'b1, 32'h0FD5BDEE);
    repeat (5) @(negedge clk);
    #1 start = 1'b1; funct3 = 3'd0; reg1 = 32'd1; reg2 = 32'd1; wd_i = 5'd3; wreg_i = 1'b0;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("busy_start_wd", 32'(wd_o), 32'd9);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
